// File: rtl/tdm_demux.sv
//------------------------------------------------------------------------------
// tdm_demux : locks to slot-0 sync and releases coherent N_CH-word frames
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tdm_demux #(
   parameter int N_CH = 4,
   parameter int W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W-1:0]      din,
   input  logic              din_valid,
   input  logic              sync,
   output logic [N_CH*W-1:0] dout,
   output logic              frame_valid,
   output logic              locked,
   output logic              sync_err
);

   localparam int SW = (N_CH > 2) ? $clog2(N_CH) : 1;
   localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
   localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

   typedef enum logic [0:0] {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [SW-1:0]       slot_q, slot_d;
   logic [W-1:0]        shadow_q [N_CH];
   logic                wr_en_d;
   logic [SW-1:0]       wr_idx_d;
   logic [N_CH*W-1:0]   dout_q, dout_d;
   logic                fv_q, fv_d;
   logic                err_q, err_d;

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      wr_en_d  = 1'b0;
      wr_idx_d = '0;
      dout_d   = dout_q;
      fv_d     = 1'b0;
      err_d    = 1'b0;
      if (din_valid) begin
         if (state_q == HUNT) begin
            if (sync) begin
               wr_en_d = 1'b1;
               slot_d  = SLOT_ONE;
               state_d = LOCKED;
            end
         end else if (slot_q == '0) begin
            if (sync) begin
               wr_en_d = 1'b1;
               slot_d  = SLOT_ONE;
            end else begin
               err_d   = 1'b1;
               state_d = HUNT;
            end
         end else if (sync) begin
            // Early sync: drop the partial frame and restart at slot 0.
            err_d   = 1'b1;
            wr_en_d = 1'b1;
            slot_d  = SLOT_ONE;
         end else begin
            wr_en_d  = 1'b1;
            wr_idx_d = slot_q;
            if (slot_q == LAST_SLOT) begin
               for (int k = 0; k < N_CH - 1; k++)
                  dout_d[k*W +: W] = shadow_q[k];
               dout_d[(N_CH-1)*W +: W] = din;
               fv_d   = 1'b1;
               slot_d = '0;
            end else begin
               slot_d = slot_q + SLOT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUNT;
         slot_q  <= '0;
         dout_q  <= '0;
         fv_q    <= 1'b0;
         err_q   <= 1'b0;
         for (int k = 0; k < N_CH; k++)
            shadow_q[k] <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         dout_q  <= dout_d;
         fv_q    <= fv_d;
         err_q   <= err_d;
         if (wr_en_d)
            shadow_q[wr_idx_d] <= din;
      end
   end

   assign dout        = dout_q;
   assign frame_valid = fv_q;
   assign sync_err    = err_q;
   assign locked      = (state_q == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
//------------------------------------------------------------------------------
// tb_tdm_demux : scoreboard bench for tdm_demux (N_CH=4, W=8)
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tdm_demux;

   localparam int N_CH = 4;
   localparam int W    = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [W-1:0]      din = '0;
   logic              din_valid = 1'b0;
   logic              sync = 1'b0;
   logic [N_CH*W-1:0] dout;
   logic              frame_valid;
   logic              locked;
   logic              sync_err;

   int n_total = 0;
   int n_bad   = 0;

   logic [N_CH*W-1:0] exp_frames [$];
   int                exp_errs = 0;

   tdm_demux #(.N_CH(N_CH), .W(W)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .sync        (sync),
      .dout        (dout),
      .frame_valid (frame_valid),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pops an expectation for every output event the DUT raises.
   always @(negedge clk) begin
      if (frame_valid) begin
         if (exp_frames.size() == 0)
            chk("frame_unexpected", 64'd1, 64'd0);
         else
            chk("frame", 64'(dout), 64'(exp_frames.pop_front()));
      end
      if (sync_err) begin
         chk("err_expected", 64'(exp_errs > 0), 64'd1);
         if (exp_errs > 0) exp_errs--;
      end
      if (frame_valid && sync_err)
         chk("fv_err_overlap", 64'd1, 64'd0);
   end

   task automatic beat(input logic v, input logic s, input logic [W-1:0] d);
      din_valid = v;
      sync      = s;
      din       = d;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      sync      = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'hEE);
   endtask

   task automatic pulse_reset(input logic v, input logic s, input logic [W-1:0] d);
      rst = 1'b1;
      beat(v, s, d);
      rst = 1'b0;
   endtask

   task automatic drain(input string tag);
      idle(3);
      chk({tag, "_frames_left"}, 64'(exp_frames.size()), 64'd0);
      chk({tag, "_errs_left"}, 64'(exp_errs), 64'd0);
   endtask

   initial begin
      pulse_reset(1'b0, 1'b0, 8'h00);
      pulse_reset(1'b0, 1'b0, 8'h00);
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_fv", 64'(frame_valid), 64'd0);
      chk("rst_locked", 64'(locked), 64'd0);
      chk("rst_err", 64'(sync_err), 64'd0);

      // Basic back-to-back frame
      beat(1, 1, 8'h11);
      chk("t1_locked", 64'(locked), 64'd1);
      beat(1, 0, 8'h22);
      beat(1, 0, 8'h33);
      chk("t1_dout_pre", 64'(dout), 64'd0);
      chk("t1_fv_pre", 64'(frame_valid), 64'd0);
      exp_frames.push_back(32'h44332211);
      beat(1, 0, 8'h44);
      chk("t1_fv_now", 64'(frame_valid), 64'd1);
      drain("t1");

      // Same frame with 3-cycle gaps
      beat(1, 1, 8'h11); idle(3);
      beat(1, 0, 8'h22); idle(3);
      beat(1, 0, 8'h33); idle(3);
      exp_frames.push_back(32'h44332211);
      beat(1, 0, 8'h44);
      drain("t2");

      // Early sync
      beat(1, 1, 8'hA0);
      beat(1, 0, 8'hA1);
      exp_errs++;
      beat(1, 1, 8'hB0);
      chk("t3_err_now", 64'(sync_err), 64'd1);
      chk("t3_locked", 64'(locked), 64'd1);
      beat(1, 0, 8'hB1);
      beat(1, 0, 8'hB2);
      exp_frames.push_back(32'hB3B2B1B0);
      beat(1, 0, 8'hB3);
      drain("t3");

      // Missing sync after a frame
      beat(1, 1, 8'hC0);
      beat(1, 0, 8'hC1);
      beat(1, 0, 8'hC2);
      exp_frames.push_back(32'hC3C2C1C0);
      beat(1, 0, 8'hC3);
      exp_errs++;
      beat(1, 0, 8'h55);
      chk("t4_locked_fell", 64'(locked), 64'd0);
      chk("t4_dout_held", 64'(dout), 64'hC3C2C1C0);
      beat(1, 0, 8'h56);
      beat(1, 0, 8'h57);
      chk("t4_still_hunt", 64'(locked), 64'd0);
      beat(1, 1, 8'hD0);
      chk("t4_relock", 64'(locked), 64'd1);
      beat(1, 0, 8'hD1);
      beat(1, 0, 8'hD2);
      exp_frames.push_back(32'hD3D2D1D0);
      beat(1, 0, 8'hD3);
      drain("t4");

      // Hunt discard from reset
      pulse_reset(1'b0, 1'b0, 8'h00);
      chk("t5_rst_dout", 64'(dout), 64'd0);
      beat(1, 0, 8'h99);
      beat(1, 0, 8'h98);
      chk("t5_hunting", 64'(locked), 64'd0);
      beat(1, 1, 8'h01);
      beat(1, 0, 8'h02);
      beat(1, 0, 8'h03);
      exp_frames.push_back(32'h04030201);
      beat(1, 0, 8'h04);
      drain("t5");

      // Reset mid-frame, with a beat presented alongside rst
      beat(1, 1, 8'h01);
      beat(1, 0, 8'h02);
      pulse_reset(1'b1, 1'b1, 8'h77);
      chk("t6_dout", 64'(dout), 64'd0);
      chk("t6_locked", 64'(locked), 64'd0);
      beat(1, 0, 8'h03);
      beat(1, 0, 8'h04);
      chk("t6_locked_after", 64'(locked), 64'd0);
      chk("t6_dout_after", 64'(dout), 64'd0);
      beat(1, 1, 8'h05);
      beat(1, 0, 8'h06);
      beat(1, 0, 8'h07);
      exp_frames.push_back(32'h08070605);
      beat(1, 0, 8'h08);
      drain("t6");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
